mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read memory (1-cycle read latency, byte-enable writes) between the CPU instruction-fetch port and the load/store port of Riscv151.
- Grants at most one requester per cycle and routes read data back to the requester that issued the read.
- Fixed priority favours data accesses; a streak limiter prevents starvation of instruction fetch.
- Also provides a free-running conflict counter that software can read as a CSR.

Parameters:
- AWIDTH, 14: word-address width of the shared memory.
- DWIDTH, 32: data width. Byte enables are DWIDTH/8 bits wide.
- MAX_STREAK, 4: maximum number of consecutive data grants while a fetch is waiting. Legal range is 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request.
- if_addr  in  AWIDTH  fetch word address.
- if_ready  out  1  fetch granted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DWIDTH  fetch read data.
- dm_req  in  1  data request.
- dm_we  in  DWIDTH/8  byte write enables; all zero means read.
- dm_addr  in  AWIDTH  data word address.
- dm_wdata  in  DWIDTH  write data.
- dm_ready  out  1  data request granted this cycle.
- dm_rvalid  out  1  data read data valid.
- dm_rdata  out  DWIDTH  data read data.
- mem_en  out  1  memory enable.
- mem_we  out  DWIDTH/8  memory byte write enables.
- mem_addr  out  AWIDTH  memory address.
- mem_din  out  DWIDTH  memory write data.
- mem_dout  in  DWIDTH  memory read data; valid the cycle after an enabled read.
- conflict_count  out  32  number of cycles in which a requester was denied.

Behaviour:
- Grant decision is combinational on the current-cycle inputs.
  - grant_dm = dm_req && !(if_req && streak == MAX_STREAK).
  - grant_if = if_req && !grant_dm.
- While rst is high: grant_dm = grant_if = 0.
- if_ready = grant_if and dm_ready = grant_dm. Ready is combinational; there is no registered handshake.
- A requester holds its req and all request fields stable until it sees ready high. A transfer occurs in any cycle where req && ready.
- Memory-side outputs:
  - mem_en = grant_if | grant_dm.
  - mem_addr = dm_addr if grant_dm, else if_addr.
  - mem_we = dm_we if grant_dm, else 0.
  - mem_din = dm_wdata.
  - A fetch never writes.
- Response tags are registers, reset to 0, updated every cycle:
  - rsp_if <= grant_if.
  - rsp_dm <= grant_dm && (dm_we == 0).
  - Writes produce no response.
- Read data outputs:
  - if_rvalid = rsp_if and dm_rvalid = rsp_dm. Read latency is exactly 1 cycle after ready.
  - if_rdata = rsp_if ? mem_dout : 0.
  - dm_rdata = rsp_dm ? mem_dout : 0.
  - Both valids are never high in the same cycle.
- streak (4-bit register, reset 0):
  - grant_dm && if_req: streak+1, saturating at MAX_STREAK.
  - grant_if, or !if_req: streak <= 0.
  - When streak == MAX_STREAK and both request, the fetch wins and streak clears.
- conflict_count (reset 0):
  - Increments by 1 in any cycle with (if_req && !grant_if) || (dm_req && !grant_dm), while rst is low.
  - Wraps from 0xFFFFFFFF to 0.
  - Counts at most 1 per cycle.
- Back-to-back transfers are allowed: a new grant may issue in the same cycle as the previous read's rvalid.
- Reset mid-operation: at the reset edge, rsp_if, rsp_dm, streak and conflict_count are cleared. A read granted in the cycle before reset never returns rvalid.
- Reset values of all outputs while rst is high:
  - Readies, rvalids, mem_en and mem_we are 0; rdata outputs are 0.
  - conflict_count is 0 from the first edge.
  - mem_addr and mem_din are don't-care.

Test Plan:
- Fetch only: if_req=1, if_addr=0x010 with memory word 0x00000013 -> if_ready=1 the same cycle; if_rvalid=1 with if_rdata=0x00000013 the next cycle; conflict_count stays 0.
- Simultaneous single requests: if_req=1 and dm_req=1 read of 0x020 (word 0xDEADBEEF) -> dm granted first and dm_rdata=0xDEADBEEF one cycle later; if granted the following cycle; conflict_count=1.
- Starvation limit: dm_req held high for 10 cycles with if_req high, MAX_STREAK=4 -> grant pattern D,D,D,D,I,D,D,D,D,I; conflict_count=10.
- Byte write then read: dm_we=4'b0011, dm_addr=0x030, dm_wdata=0xAABBCCDD over old word 0x11223344 -> no dm_rvalid for the write; a subsequent read returns 0x1122CCDD.
- Reset mid-read: dm read granted, rst asserted on the next edge -> dm_rvalid stays 0, streak=0, conflict_count=0; no grants while rst=1.
- Counter wrap: force conflict_count to 0xFFFFFFFF, then one conflict cycle -> conflict_count=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous-read memory between instruction fetch and load/store.
// Data accesses win by default; a streak limiter guarantees fetch progress.
module mem_port_arbiter #(
  parameter int unsigned AWIDTH     = 14,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [AWIDTH-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DWIDTH-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic [DWIDTH/8-1:0] dm_we,
  input  logic [AWIDTH-1:0]   dm_addr,
  input  logic [DWIDTH-1:0]   dm_wdata,
  output logic                dm_ready,
  output logic                dm_rvalid,
  output logic [DWIDTH-1:0]   dm_rdata,
  output logic                mem_en,
  output logic [DWIDTH/8-1:0] mem_we,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [DWIDTH-1:0]   mem_din,
  input  logic [DWIDTH-1:0]   mem_dout,
  output logic [31:0]         conflict_count
);

  localparam logic [3:0] StreakMax = 4'(MAX_STREAK);

  logic        grant_if, grant_dm, conflict;
  logic        rsp_if_q, rsp_dm_q;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] conflict_q, conflict_d;

  always_comb begin
    grant_dm = 1'b0;
    grant_if = 1'b0;
    if (!rst) begin
      grant_dm = dm_req && !(if_req && (streak_q == StreakMax));
      grant_if = if_req && !grant_dm;
    end
  end

  always_comb begin
    conflict   = (if_req && !grant_if) || (dm_req && !grant_dm);
    conflict_d = conflict_q + 32'(conflict);
    streak_d   = '0;
    // Only data wins that leave a fetch waiting count towards the streak.
    if (grant_dm && if_req) begin
      streak_d = (streak_q == StreakMax) ? StreakMax : streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_if_q   <= 1'b0;
      rsp_dm_q   <= 1'b0;
      streak_q   <= '0;
      conflict_q <= '0;
    end else begin
      rsp_if_q   <= grant_if;
      rsp_dm_q   <= grant_dm && (dm_we == '0);
      streak_q   <= streak_d;
      conflict_q <= conflict_d;
    end
  end

  assign if_ready       = grant_if;
  assign dm_ready       = grant_dm;
  assign mem_en         = grant_if | grant_dm;
  assign mem_we         = grant_dm ? dm_we : '0;
  assign mem_addr       = grant_dm ? dm_addr : if_addr;
  assign mem_din        = dm_wdata;
  // A tag left over from the cycle before reset must not surface while reset is held.
  assign if_rvalid      = rsp_if_q && !rst;
  assign dm_rvalid      = rsp_dm_q && !rst;
  assign if_rdata       = if_rvalid ? mem_dout : '0;
  assign dm_rdata       = dm_rvalid ? mem_dout : '0;
  assign conflict_count = conflict_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed corner cases, a vector table for the
// starvation pattern, and randomized traffic against a behavioural reference model.
module tb_mem_port_arbiter;

  localparam int MaxStreak = 4;

  logic        clk, rst;
  logic        if_req, if_ready, if_rvalid;
  logic [13:0] if_addr;
  logic [31:0] if_rdata;
  logic        dm_req, dm_ready, dm_rvalid;
  logic [3:0]  dm_we;
  logic [13:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic [31:0] conflict_count;

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter #(
    .AWIDTH    (14),
    .DWIDTH    (32),
    .MAX_STREAK(MaxStreak)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_ready      (if_ready),
    .if_rvalid     (if_rvalid),
    .if_rdata      (if_rdata),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_ready      (dm_ready),
    .dm_rvalid     (dm_rvalid),
    .dm_rdata      (dm_rdata),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout),
    .conflict_count(conflict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory device seen by the DUT and an independent shadow used by the reference model.
  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
      end
      mem_dout <= mem[mem_addr];
    end
  end

  typedef struct {
    logic exp_if_ready;
    logic exp_dm_ready;
    logic exp_if_rvalid;
    logic exp_dm_rvalid;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ir, input logic [13:0] ia, input logic dr, input logic [3:0] we,
                       input logic [13:0] da, input logic [31:0] wd);
    @(negedge clk);
    if_req   = ir;
    if_addr  = ia;
    dm_req   = dr;
    dm_we    = we;
    dm_addr  = da;
    dm_wdata = wd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model state
  int          m_streak;
  logic [31:0] m_conf, m_data;
  logic        m_pif, m_pdm;
  logic        gi, gd, if_done, dm_done;

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i]     = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
      ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
    end
    mem[14'h010] = 32'h0000_0013;
    mem[14'h020] = 32'hDEAD_BEEF;
    mem[14'h030] = 32'h1122_3344;
    mem_dout = '0;

    // D,D,D,D,I,D,D,D,D,I with read data one cycle after each grant
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state with both requesters active
    rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_we = '0;
    if_addr = 14'h010; dm_addr = 14'h020; dm_wdata = '0;
    @(posedge clk);
    @(negedge clk); #1;
    chk("rst_if_ready", 32'(if_ready), 0);
    chk("rst_dm_ready", 32'(dm_ready), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_rvalids", {30'd0, if_rvalid, dm_rvalid}, 0);
    chk("rst_rdata", if_rdata | dm_rdata, 0);
    chk("rst_conflict", conflict_count, 0);

    // Fetch only
    do_reset();
    drive(1'b1, 14'h010, 1'b0, 4'h0, 14'h000, 32'h0);
    chk("fo_if_ready", 32'(if_ready), 1);
    chk("fo_dm_ready", 32'(dm_ready), 0);
    chk("fo_mem_addr", 32'(mem_addr), 32'h010);
    chk("fo_mem_en_we", {27'd0, mem_en, mem_we}, 32'h10);
    drive(1'b0, 14'h000, 1'b0, 4'h0, 14'h000, 32'h0);
    chk("fo_if_rvalid", 32'(if_rvalid), 1);
    chk("fo_if_rdata", if_rdata, 32'h0000_0013);
    chk("fo_conflict", conflict_count, 0);

    // Simultaneous requests: data first, then fetch
    do_reset();
    drive(1'b1, 14'h010, 1'b1, 4'h0, 14'h020, 32'h0);
    chk("sim_dm_first", {30'd0, if_ready, dm_ready}, 32'b01);
    chk("sim_mem_addr", 32'(mem_addr), 32'h020);
    drive(1'b1, 14'h010, 1'b0, 4'h0, 14'h020, 32'h0);
    chk("sim_if_second", {30'd0, if_ready, dm_ready}, 32'b10);
    chk("sim_dm_rvalid", 32'(dm_rvalid), 1);
    chk("sim_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("sim_if_rvalid_lo", 32'(if_rvalid), 0);
    drive(1'b0, 14'h010, 1'b0, 4'h0, 14'h020, 32'h0);
    chk("sim_if_rdata", {if_rvalid, dm_rvalid, 30'd0} | 32'(if_rdata), 32'h8000_0013);
    chk("sim_conflict", conflict_count, 1);

    // Starvation limit, table driven
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 14'h010, 1'b1, 4'h0, 14'h020, 32'h0);
      chk($sformatf("stv%0d_grant", i), {30'd0, if_ready, dm_ready},
          {30'd0, vecs[i].exp_if_ready, vecs[i].exp_dm_ready});
      chk($sformatf("stv%0d_rvalid", i), {30'd0, if_rvalid, dm_rvalid},
          {30'd0, vecs[i].exp_if_rvalid, vecs[i].exp_dm_rvalid});
      chk($sformatf("stv%0d_conflict", i), conflict_count, 32'(i));
    end
    drive(1'b0, 14'h010, 1'b0, 4'h0, 14'h020, 32'h0);
    chk("stv_last_if_rdata", if_rdata, 32'h0000_0013);
    chk("stv_conflict", conflict_count, 10);

    // Byte write then read back
    do_reset();
    drive(1'b0, 14'h010, 1'b1, 4'b0011, 14'h030, 32'hAABB_CCDD);
    chk("bw_dm_ready", 32'(dm_ready), 1);
    chk("bw_mem_we", 32'(mem_we), 32'b0011);
    chk("bw_mem_din", mem_din, 32'hAABB_CCDD);
    drive(1'b0, 14'h010, 1'b1, 4'b0000, 14'h030, 32'h0);
    chk("bw_no_rvalid", 32'(dm_rvalid), 0);
    drive(1'b0, 14'h010, 1'b0, 4'b0000, 14'h030, 32'h0);
    chk("bw_rvalid", 32'(dm_rvalid), 1);
    chk("bw_rdata", dm_rdata, 32'h1122_CCDD);

    // Reset mid-read after building a full data streak
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 14'h010, 1'b1, 4'h0, 14'h020, 32'h0);
    chk("rmr_last_dm_grant", 32'(dm_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rmr_rst_grants", {30'd0, if_ready, dm_ready}, 0);
    chk("rmr_rst_mem_en", 32'(mem_en), 0);
    chk("rmr_rst_dm_rvalid", 32'(dm_rvalid), 0);
    chk("rmr_rst_dm_rdata", dm_rdata, 0);
    @(negedge clk); #1;
    chk("rmr_conflict", conflict_count, 0);
    chk("rmr_rst_grants2", {30'd0, if_ready, dm_ready}, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmr_streak_cleared", {30'd0, if_ready, dm_ready}, 32'b01);
    chk("rmr_no_late_rvalid", {30'd0, if_rvalid, dm_rvalid}, 0);

    // Counter wrap
    do_reset();
    @(negedge clk);
    force dut.conflict_q = 32'hFFFF_FFFF;
    #1;
    release dut.conflict_q;
    drive(1'b1, 14'h010, 1'b1, 4'h0, 14'h020, 32'h0);
    chk("wrap_pre", conflict_count, 32'hFFFF_FFFF);
    drive(1'b0, 14'h010, 1'b0, 4'h0, 14'h020, 32'h0);
    chk("wrap_post", conflict_count, 0);

    // Randomized traffic against the reference model
    do_reset();
    m_streak = 0; m_conf = '0; m_data = '0; m_pif = 1'b0; m_pdm = 1'b0;
    if_done = 1'b1; dm_done = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      if (!if_req || if_done) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 14'h100 + 14'($urandom_range(0, 63));
      end
      if (!dm_req || dm_done) begin
        dm_req   = ($urandom_range(0, 3) != 0);
        dm_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        dm_addr  = 14'h100 + 14'($urandom_range(0, 63));
        dm_wdata = $urandom;
      end
      #1;
      // Data wins unless it has already won MaxStreak times in a row over a waiting fetch.
      gd = !rst && dm_req && !(if_req && m_streak == MaxStreak);
      gi = !rst && if_req && !gd;
      chk("rnd_grants", {30'd0, if_ready, dm_ready}, {30'd0, gi, gd});
      chk("rnd_mem_en", 32'(mem_en), 32'(gi | gd));
      chk("rnd_mem_we", 32'(mem_we), gd ? 32'(dm_we) : 0);
      if (gi || gd) chk("rnd_mem_addr", 32'(mem_addr), gd ? 32'(dm_addr) : 32'(if_addr));
      if (gd && dm_we != 0) chk("rnd_mem_din", mem_din, dm_wdata);
      chk("rnd_rvalids", {30'd0, if_rvalid, dm_rvalid},
          {30'd0, m_pif && !rst, m_pdm && !rst});
      chk("rnd_if_rdata", if_rdata, (m_pif && !rst) ? m_data : 0);
      chk("rnd_dm_rdata", dm_rdata, (m_pdm && !rst) ? m_data : 0);
      chk("rnd_conflict", conflict_count, m_conf);
      if (rst) begin
        m_pif = 1'b0; m_pdm = 1'b0; m_streak = 0; m_conf = '0;
      end else begin
        m_pif = gi;
        m_pdm = gd && (dm_we == 0);
        if (gi) m_data = ref_mem[if_addr];
        if (gd) begin
          m_data = ref_mem[dm_addr];
          for (int b = 0; b < 4; b++) begin
            if (dm_we[b]) ref_mem[dm_addr][8*b +: 8] = dm_wdata[8*b +: 8];
          end
        end
        if (gd && if_req) m_streak = (m_streak < MaxStreak) ? m_streak + 1 : MaxStreak;
        else m_streak = 0;
        if ((if_req && !gi) || (dm_req && !gd)) m_conf = m_conf + 1;
      end
      if_done = gi;
      dm_done = gd;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
